// File: rtl/rv32_pkg.sv
// Shared RV32 types for the ID->EX operand stage: ALU op codes and operand selects.
package rv32_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_SRA   = 4'b0110,
    ALU_SLL   = 4'b0111,
    ALU_SLT   = 4'b1000,
    ALU_SLTU  = 4'b1001,
    ALU_PASSB = 4'b1110,
    ALU_PASSA = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    ASEL_RS1  = 2'd0,
    ASEL_PC   = 2'd1,
    ASEL_ZERO = 2'd2,
    ASEL_RSVD = 2'd3   // treated as zero
  } asel_e;

  typedef enum logic {
    BSEL_RS2 = 1'b0,
    BSEL_IMM = 1'b1
  } bsel_e;

endpackage

// File: rtl/operand_fwd_mux.sv
// Per-source bypass: EX/MEM beats WB beats regfile; x0 is hard zero.
module operand_fwd_mux #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] addr,
  input  logic [XLEN-1:0]   rf_data,
  input  logic              exm_reg_we,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [XLEN-1:0]   exm_result,
  input  logic              wb_reg_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   data
);

  // Priority select; the x0 test also masks a non-zero regfile read of x0.
  always_comb begin
    data = rf_data;
    if (addr == '0)                             data = '0;
    else if (exm_reg_we && (exm_rd == addr))    data = exm_result;
    else if (wb_reg_we && (wb_rd == addr))      data = wb_data;
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID->EX pipeline register: operand select with forwarding, load-use stall, flush squash.
module id_ex_operand_stage #(
  parameter int XLEN   = rv32_pkg::XLEN,
  parameter int REG_AW = rv32_pkg::REG_AW,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic              id_rs1_use,
  input  logic              id_rs2_use,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [3:0]        id_alusel,
  input  logic [1:0]        id_asel,
  input  logic              id_bsel,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_we,
  input  logic              id_mem_rd,
  input  logic              id_mem_wr,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic              exm_reg_we,
  input  logic [XLEN-1:0]   exm_result,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_we,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic              stall_out,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_input_a,
  output logic [XLEN-1:0]   ex_input_b,
  output logic [3:0]        ex_alusel,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_we,
  output logic              ex_mem_rd,
  output logic              ex_mem_wr,
  output logic [CNT_W-1:0]  stall_count
);

  import rv32_pkg::*;

  logic [XLEN-1:0]   rs1_fwd, rs2_fwd, op_a, op_b;
  logic              hazard, bubble;

  logic              ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]   ex_input_a_q, ex_input_a_d;
  logic [XLEN-1:0]   ex_input_b_q, ex_input_b_d;
  logic [3:0]        ex_alusel_q, ex_alusel_d;
  logic [XLEN-1:0]   ex_store_data_q, ex_store_data_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic              ex_reg_we_q, ex_reg_we_d;
  logic              ex_mem_rd_q, ex_mem_rd_d;
  logic              ex_mem_wr_q, ex_mem_wr_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;

  operand_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .addr(id_rs1_addr), .rf_data(id_rs1_data),
    .exm_reg_we(exm_reg_we), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_reg_we(wb_reg_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .data(rs1_fwd)
  );

  operand_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .addr(id_rs2_addr), .rf_data(id_rs2_data),
    .exm_reg_we(exm_reg_we), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_reg_we(wb_reg_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .data(rs2_fwd)
  );

  // Load in EX whose rd feeds the ID instruction; flush overrides the stall.
  always_comb begin
    hazard    = ex_valid_q && ex_mem_rd_q && (ex_rd_q != '0) &&
                ((id_rs1_use && (id_rs1_addr == ex_rd_q)) ||
                 (id_rs2_use && (id_rs2_addr == ex_rd_q)));
    stall_out = id_valid && !flush && hazard;
    bubble    = flush || stall_out || !id_valid;
  end

  // Operand selection from forwarded register values, PC, immediate or zero.
  always_comb begin
    case (asel_e'(id_asel))
      ASEL_RS1: op_a = rs1_fwd;
      ASEL_PC:  op_a = id_pc;
      default:  op_a = '0;
    endcase
    op_b = (bsel_e'(id_bsel) == BSEL_IMM) ? id_imm : rs2_fwd;
  end

  // Next-state: control bits clear on any bubble, datapath holds only on stall.
  always_comb begin
    ex_valid_d      = ex_valid_q;
    ex_input_a_d    = ex_input_a_q;
    ex_input_b_d    = ex_input_b_q;
    ex_alusel_d     = ex_alusel_q;
    ex_store_data_d = ex_store_data_q;
    ex_rd_d         = ex_rd_q;
    ex_reg_we_d     = ex_reg_we_q;
    ex_mem_rd_d     = ex_mem_rd_q;
    ex_mem_wr_d     = ex_mem_wr_q;
    stall_count_d   = stall_count_q;

    if (bubble) begin
      ex_valid_d  = 1'b0;
      ex_reg_we_d = 1'b0;
      ex_mem_rd_d = 1'b0;
      ex_mem_wr_d = 1'b0;
    end else begin
      ex_valid_d  = 1'b1;
      ex_reg_we_d = id_reg_we;
      ex_mem_rd_d = id_mem_rd;
      ex_mem_wr_d = id_mem_wr;
    end

    if (!stall_out) begin
      ex_input_a_d    = op_a;
      ex_input_b_d    = op_b;
      ex_alusel_d     = id_alusel;
      ex_store_data_d = rs2_fwd;
      ex_rd_d         = id_rd;
    end

    if (stall_out && (stall_count_q != '1))
      stall_count_d = stall_count_q + CNT_W'(1);
  end

  // Stage register with async clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q      <= 1'b0;
      ex_input_a_q    <= '0;
      ex_input_b_q    <= '0;
      ex_alusel_q     <= ALU_ADD;
      ex_store_data_q <= '0;
      ex_rd_q         <= '0;
      ex_reg_we_q     <= 1'b0;
      ex_mem_rd_q     <= 1'b0;
      ex_mem_wr_q     <= 1'b0;
      stall_count_q   <= '0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_input_a_q    <= ex_input_a_d;
      ex_input_b_q    <= ex_input_b_d;
      ex_alusel_q     <= ex_alusel_d;
      ex_store_data_q <= ex_store_data_d;
      ex_rd_q         <= ex_rd_d;
      ex_reg_we_q     <= ex_reg_we_d;
      ex_mem_rd_q     <= ex_mem_rd_d;
      ex_mem_wr_q     <= ex_mem_wr_d;
      stall_count_q   <= stall_count_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_input_a    = ex_input_a_q;
  assign ex_input_b    = ex_input_b_q;
  assign ex_alusel     = ex_alusel_q;
  assign ex_store_data = ex_store_data_q;
  assign ex_rd         = ex_rd_q;
  assign ex_reg_we     = ex_reg_we_q;
  assign ex_mem_rd     = ex_mem_rd_q;
  assign ex_mem_wr     = ex_mem_wr_q;
  assign stall_count   = stall_count_q;

endmodule
